// File: rtl/vector_decode_pkg.sv
// rtl/vector_decode_pkg.sv - encodings, micro-op types and field constants for the vector decoder
package vector_decode_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_STORE = 7'b0100111;
    localparam logic [6:0] OPC_ARITH = 7'b1010111;

    localparam logic [2:0] F3_OPIVV = 3'b000;
    localparam logic [2:0] F3_OPFVV = 3'b001;
    localparam logic [2:0] F3_OPMVV = 3'b010;
    localparam logic [2:0] F3_OPIVI = 3'b011;
    localparam logic [2:0] F3_OPIVX = 3'b100;
    localparam logic [2:0] F3_OPFVF = 3'b101;
    localparam logic [2:0] F3_OPMVX = 3'b110;
    localparam logic [2:0] F3_OPCFG = 3'b111;

    localparam logic [5:0] F6_ADD    = 6'b000000;
    localparam logic [5:0] F6_SUB    = 6'b000010;
    localparam logic [5:0] F6_MINU   = 6'b000100;
    localparam logic [5:0] F6_MIN    = 6'b000101;
    localparam logic [5:0] F6_AND    = 6'b001001;
    localparam logic [5:0] F6_OR     = 6'b001010;
    localparam logic [5:0] F6_XOR    = 6'b001011;
    localparam logic [5:0] F6_MERGE  = 6'b010111;
    localparam logic [5:0] F6_MSEQ   = 6'b011000;
    localparam logic [5:0] F6_MSNE   = 6'b011001;
    localparam logic [5:0] F6_MSLTU  = 6'b011010;
    localparam logic [5:0] F6_MSLT   = 6'b011011;
    localparam logic [5:0] F6_MSLEU  = 6'b011100;
    localparam logic [5:0] F6_MSLE   = 6'b011101;
    localparam logic [5:0] F6_MSGTU  = 6'b011110;
    localparam logic [5:0] F6_MSGT   = 6'b011111;
    localparam logic [5:0] F6_SLL    = 6'b100101;
    localparam logic [5:0] F6_SRL    = 6'b101000;
    localparam logic [5:0] F6_SRA    = 6'b101001;
    localparam logic [5:0] F6_MULHU  = 6'b100100;
    localparam logic [5:0] F6_MUL    = 6'b100101;
    localparam logic [5:0] F6_MULHSU = 6'b100110;
    localparam logic [5:0] F6_MULH   = 6'b100111;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MERGE,
        OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_SLL, OP_SRL, OP_SRA,
        OP_MSEQ, OP_MSNE, OP_MSLTU, OP_MSLT, OP_MSLEU, OP_MSLE,
        OP_MSGTU, OP_MSGT, OP_MINU, OP_MIN
    } alu_op_t;

    typedef enum logic [1:0] {
        CLASS_ARITH   = 2'b00,
        CLASS_CFG     = 2'b01,
        CLASS_ILLEGAL = 2'b10
    } uop_class_t;

    typedef enum logic [1:0] {
        SRC_VV = 2'b00,
        SRC_VX = 2'b01,
        SRC_VI = 2'b10
    } src_sel_t;

    typedef struct packed {
        uop_class_t  cls;
        alu_op_t     op;
        src_sel_t    src;
        logic [4:0]  vd;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic        vm;
        logic [31:0] scalar;
        logic [1:0]  sew;
    } uop_t;

endpackage

// File: rtl/vector_vtype_unit.sv
// rtl/vector_vtype_unit.sv - architectural vl/vtype state and vsetvli/vsetivli vl computation
module vector_vtype_unit #(
    parameter int VLEN = 512,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_en,
    input  logic            is_ivli,
    input  logic [10:0]     vtype_bits,
    input  logic [4:0]      avl_field,
    input  logic [4:0]      rd,
    input  logic [31:0]     rs1_value,
    output logic [VL_W-1:0] vl,
    output logic            vill,
    output logic [1:0]      sew,
    output logic [VL_W-1:0] new_vl,
    output logic            new_vill,
    output logic [1:0]      new_sew
);

    logic [2:0]  vsew;
    logic [2:0]  vlmul;
    logic        supported;
    logic [31:0] vlmax32;
    logic [31:0] avl;

    assign vsew  = vtype_bits[5:3];
    assign vlmul = vtype_bits[2:0];

    always_comb begin
        // bit 30 is part of the vsetivli opcode, so only vsetvli has it reserved
        supported = (vsew <= 3'b010) && !vlmul[2] && (vtype_bits[9:6] == 4'b0000)
                    && (is_ivli || !vtype_bits[10]);
        vlmax32 = (32'(VLEN) >> (32'd3 + {29'b0, vsew})) << vlmul[1:0];
        if (is_ivli)
            avl = {27'b0, avl_field};
        else if (avl_field != 5'd0)
            avl = rs1_value;
        else if (rd != 5'd0)
            avl = vlmax32;
        else
            avl = {{(32-VL_W){1'b0}}, vl};
        if (supported) begin
            new_vl   = (avl < vlmax32) ? avl[VL_W-1:0] : vlmax32[VL_W-1:0];
            new_vill = 1'b0;
            new_sew  = vsew[1:0];
        end else begin
            new_vl   = '0;
            new_vill = 1'b1;
            new_sew  = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vl   <= '0;
            vill <= 1'b1;
            sew  <= 2'b00;
        end else if (cfg_en) begin
            vl   <= new_vl;
            vill <= new_vill;
            sew  <= new_sew;
        end
    end

endmodule

// File: rtl/vector_instr_decoder.sv
// rtl/vector_instr_decoder.sv - vector decode/issue stage: one registered micro-op slot with valid/ready
module vector_instr_decoder
    import vector_decode_pkg::*;
#(
    parameter int VLEN = 512,
    parameter int VL_W = $clog2(VLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr_i,
    input  logic [31:0]     rs1_value_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    output logic            uop_valid_o,
    input  logic            uop_ready_i,
    output logic [1:0]      uop_class_o,
    output logic [4:0]      uop_op_o,
    output logic [1:0]      uop_src_o,
    output logic [4:0]      uop_vd_o,
    output logic [4:0]      uop_vs1_o,
    output logic [4:0]      uop_vs2_o,
    output logic            uop_vm_o,
    output logic [31:0]     uop_scalar_o,
    output logic [VL_W-1:0] uop_vl_o,
    output logic [1:0]      uop_sew_o,
    output logic [VL_W-1:0] vl_o,
    output logic            vill_o
);

    logic [5:0] funct6;
    logic [2:0] funct3;
    logic [6:0] opcode;
    logic [4:0] imm5;
    logic       vm;

    assign funct6 = instr_i[31:26];
    assign vm     = instr_i[25];
    assign imm5   = instr_i[19:15];
    assign funct3 = instr_i[14:12];
    assign opcode = instr_i[6:0];

    logic            accept;
    logic            cfg_form;
    logic [VL_W-1:0] cur_vl;
    logic            cur_vill;
    logic [1:0]      cur_sew;
    logic [VL_W-1:0] new_vl;
    logic            new_vill;
    logic [1:0]      new_sew;

    assign instr_ready_o = !uop_valid_o || uop_ready_i;
    assign accept        = instr_valid_i && instr_ready_o;
    // vsetvli (bit31=0) and vsetivli (11); vsetvl (10) falls through to ILLEGAL
    assign cfg_form      = (opcode == OPC_ARITH) && (funct3 == F3_OPCFG)
                           && (!instr_i[31] || instr_i[30]);

    vector_vtype_unit #(.VLEN(VLEN), .VL_W(VL_W)) u_vtype (
        .clk        (clk),
        .reset      (reset),
        .cfg_en     (accept && cfg_form),
        .is_ivli    (instr_i[31]),
        .vtype_bits (instr_i[30:20]),
        .avl_field  (imm5),
        .rd         (instr_i[11:7]),
        .rs1_value  (rs1_value_i),
        .vl         (cur_vl),
        .vill       (cur_vill),
        .sew        (cur_sew),
        .new_vl     (new_vl),
        .new_vill   (new_vill),
        .new_sew    (new_sew)
    );

    alu_op_t op_sel;
    logic    ok_vv, ok_vx, ok_vi, shift_imm;

    always_comb begin
        op_sel    = OP_NOP;
        ok_vv     = 1'b0;
        ok_vx     = 1'b0;
        ok_vi     = 1'b0;
        shift_imm = 1'b0;
        if (funct3 == F3_OPMVV || funct3 == F3_OPMVX) begin
            case (funct6)
                F6_MUL:    begin op_sel = OP_MUL;    ok_vv = 1'b1; ok_vx = 1'b1; end
                F6_MULH:   begin op_sel = OP_MULH;   ok_vv = 1'b1; ok_vx = 1'b1; end
                F6_MULHU:  begin op_sel = OP_MULHU;  ok_vv = 1'b1; ok_vx = 1'b1; end
                F6_MULHSU: begin op_sel = OP_MULHSU; ok_vv = 1'b1; ok_vx = 1'b1; end
                default: ;
            endcase
        end else begin
            case (funct6)
                F6_ADD:   begin op_sel = OP_ADD;   {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_AND:   begin op_sel = OP_AND;   {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_OR:    begin op_sel = OP_OR;    {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_XOR:   begin op_sel = OP_XOR;   {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_SLL:   begin op_sel = OP_SLL;   {ok_vv, ok_vx, ok_vi} = 3'b111; shift_imm = 1'b1; end
                F6_SRL:   begin op_sel = OP_SRL;   {ok_vv, ok_vx, ok_vi} = 3'b111; shift_imm = 1'b1; end
                F6_SRA:   begin op_sel = OP_SRA;   {ok_vv, ok_vx, ok_vi} = 3'b111; shift_imm = 1'b1; end
                F6_MSEQ:  begin op_sel = OP_MSEQ;  {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_MSNE:  begin op_sel = OP_MSNE;  {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_MSLEU: begin op_sel = OP_MSLEU; {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_MSLE:  begin op_sel = OP_MSLE;  {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_MERGE: begin op_sel = OP_MERGE; {ok_vv, ok_vx, ok_vi} = 3'b111; end
                F6_SUB:   begin op_sel = OP_SUB;   {ok_vv, ok_vx, ok_vi} = 3'b110; end
                F6_MINU:  begin op_sel = OP_MINU;  {ok_vv, ok_vx, ok_vi} = 3'b110; end
                F6_MIN:   begin op_sel = OP_MIN;   {ok_vv, ok_vx, ok_vi} = 3'b110; end
                F6_MSLTU: begin op_sel = OP_MSLTU; {ok_vv, ok_vx, ok_vi} = 3'b110; end
                F6_MSLT:  begin op_sel = OP_MSLT;  {ok_vv, ok_vx, ok_vi} = 3'b110; end
                F6_MSGTU: begin op_sel = OP_MSGTU; {ok_vv, ok_vx, ok_vi} = 3'b011; end
                F6_MSGT:  begin op_sel = OP_MSGT;  {ok_vv, ok_vx, ok_vi} = 3'b011; end
                default: ;
            endcase
        end
    end

    src_sel_t        src_sel;
    logic            src_ok;
    logic            arith_ok;
    uop_t            uop_d, uop_q;
    logic [VL_W-1:0] uop_vl_d, uop_vl_q;
    logic            valid_q;

    always_comb begin
        src_sel = SRC_VI;
        src_ok  = 1'b0;
        case (funct3)
            F3_OPIVV, F3_OPMVV: begin src_sel = SRC_VV; src_ok = ok_vv; end
            F3_OPIVX, F3_OPMVX: begin src_sel = SRC_VX; src_ok = ok_vx; end
            F3_OPIVI:           begin src_sel = SRC_VI; src_ok = ok_vi; end
            default: ;
        endcase
        arith_ok = (opcode == OPC_ARITH) && src_ok && !cur_vill
                   && !(op_sel == OP_MERGE && vm);

        uop_d     = '0;
        uop_d.vd  = instr_i[11:7];
        uop_d.vs1 = imm5;
        uop_d.vs2 = instr_i[24:20];
        uop_d.vm  = vm;
        uop_d.sew = cur_sew;
        uop_vl_d  = cur_vl;
        if (cfg_form) begin
            uop_d.cls    = CLASS_CFG;
            uop_d.scalar = {{(32-VL_W){1'b0}}, new_vl};
            uop_d.sew    = new_sew;
            uop_vl_d     = new_vl;
        end else if (arith_ok) begin
            uop_d.cls = CLASS_ARITH;
            uop_d.op  = op_sel;
            uop_d.src = src_sel;
            if (src_sel == SRC_VX)
                uop_d.scalar = rs1_value_i;
            else if (src_sel == SRC_VI)
                uop_d.scalar = shift_imm ? {27'b0, imm5} : {{27{imm5[4]}}, imm5};
        end else begin
            uop_d.cls = CLASS_ILLEGAL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            uop_q    <= '0;
            uop_vl_q <= '0;
        end else if (instr_ready_o) begin
            valid_q <= instr_valid_i;
            if (instr_valid_i) begin
                uop_q    <= uop_d;
                uop_vl_q <= uop_vl_d;
            end
        end
    end

    assign uop_valid_o  = valid_q;
    assign uop_class_o  = uop_q.cls;
    assign uop_op_o     = uop_q.op;
    assign uop_src_o    = uop_q.src;
    assign uop_vd_o     = uop_q.vd;
    assign uop_vs1_o    = uop_q.vs1;
    assign uop_vs2_o    = uop_q.vs2;
    assign uop_vm_o     = uop_q.vm;
    assign uop_scalar_o = uop_q.scalar;
    assign uop_sew_o    = uop_q.sew;
    assign uop_vl_o     = uop_vl_q;
    assign vl_o         = cur_vl;
    assign vill_o       = cur_vill;

endmodule

// File: tb/tb_vector_instr_decoder.sv
// tb/tb_vector_instr_decoder.sv - directed self-checking bench for vector_instr_decoder
module tb_vector_instr_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] rs1_value;
    logic        instr_valid;
    logic        instr_ready;
    logic        uop_valid;
    logic        uop_ready;
    logic [1:0]  uop_class;
    logic [4:0]  uop_op;
    logic [1:0]  uop_src;
    logic [4:0]  uop_vd, uop_vs1, uop_vs2;
    logic        uop_vm;
    logic [31:0] uop_scalar;
    logic [9:0]  uop_vl;
    logic [1:0]  uop_sew;
    logic [9:0]  vl;
    logic        vill;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    vector_instr_decoder #(.VLEN(512)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_i       (instr),
        .rs1_value_i   (rs1_value),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .uop_valid_o   (uop_valid),
        .uop_ready_i   (uop_ready),
        .uop_class_o   (uop_class),
        .uop_op_o      (uop_op),
        .uop_src_o     (uop_src),
        .uop_vd_o      (uop_vd),
        .uop_vs1_o     (uop_vs1),
        .uop_vs2_o     (uop_vs2),
        .uop_vm_o      (uop_vm),
        .uop_scalar_o  (uop_scalar),
        .uop_vl_o      (uop_vl),
        .uop_sew_o     (uop_sew),
        .vl_o          (vl),
        .vill_o        (vill)
    );

    function automatic logic [31:0] arith(input logic [5:0] f6, input logic m, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] d);
        return {f6, m, s2, s1, f3, d, 7'b1010111};
    endfunction

    function automatic logic [31:0] vsetvli(input logic [2:0] vsew, input logic [2:0] vlmul,
                                            input logic [4:0] rs1, input logic [4:0] rd);
        return {1'b0, 5'b0, vsew, vlmul, rs1, 3'b111, rd, 7'b1010111};
    endfunction

    function automatic logic [31:0] vsetivli(input logic [2:0] vsew, input logic [2:0] vlmul,
                                             input logic [4:0] uimm, input logic [4:0] rd);
        return {2'b11, 4'b0, vsew, vlmul, uimm, 3'b111, rd, 7'b1010111};
    endfunction

    // offer one instruction, wait (bounded) for acceptance, leave the uop visible
    task automatic send(input logic [31:0] w, input logic [31:0] r);
        int n = 0;
        instr = w;
        rs1_value = r;
        instr_valid = 1'b1;
        #1;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (instr_ready !== 1'b1) begin
            failed++;
            $display("FAIL send_timeout ready=%b required=1", instr_ready);
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        tests++; if (uop_valid !== 1'b0) begin failed++; $display("FAIL reset_uop_valid got=%b want=0", uop_valid); end
        tests++; if (vl !== 10'd0) begin failed++; $display("FAIL reset_vl got=%0d want=0", vl); end
        tests++; if (vill !== 1'b1) begin failed++; $display("FAIL reset_vill got=%b want=1", vill); end
        tests++; if (instr_ready !== 1'b1) begin failed++; $display("FAIL reset_ready got=%b want=1", instr_ready); end
        tests++; if ({uop_class, uop_op, uop_vd, uop_scalar, uop_vl} !== '0) begin
            failed++; $display("FAIL reset_uop_fields got=%0h want=0", {uop_class, uop_op, uop_vd, uop_scalar, uop_vl});
        end
    endtask

    task automatic test_illegal_when_vill;
        send(32'h022081D7, 32'h0);
        tests++; if (uop_valid !== 1'b1) begin failed++; $display("FAIL vill_add_valid got=%b want=1", uop_valid); end
        tests++; if (uop_class !== 2'b10 || uop_op !== 5'd0) begin
            failed++; $display("FAIL vill_add_class got=%0d/%0d want=2/0", uop_class, uop_op);
        end
    endtask

    task automatic test_cfg;
        send(vsetvli(3'b010, 3'b000, 5'd5, 5'd1), 32'd100);
        tests++; if (uop_class !== 2'b01) begin failed++; $display("FAIL cfg_class got=%0d want=1", uop_class); end
        tests++; if (uop_vl !== 10'd16) begin failed++; $display("FAIL cfg_uop_vl got=%0d want=16", uop_vl); end
        tests++; if (uop_scalar !== 32'd16) begin failed++; $display("FAIL cfg_scalar got=%0d want=16", uop_scalar); end
        tests++; if (vill !== 1'b0 || vl !== 10'd16) begin failed++; $display("FAIL cfg_state vill=%b vl=%0d want 0/16", vill, vl); end
    endtask

    task automatic test_arith;
        send(32'h022081D7, 32'h0);
        tests++; if (uop_valid !== 1'b1 || uop_class !== 2'b00 || uop_op !== 5'd1 || uop_src !== 2'b00) begin
            failed++; $display("FAIL vadd_vv_op got=%b/%0d/%0d/%0d want=1/0/1/0", uop_valid, uop_class, uop_op, uop_src);
        end
        tests++; if ({uop_vd, uop_vs2, uop_vs1, uop_vm} !== {5'd3, 5'd2, 5'd1, 1'b1}) begin
            failed++; $display("FAIL vadd_vv_regs got=%0d,%0d,%0d,%b want=3,2,1,1", uop_vd, uop_vs2, uop_vs1, uop_vm);
        end
        tests++; if (uop_vl !== 10'd16 || uop_sew !== 2'b10) begin
            failed++; $display("FAIL vadd_vv_vl got=%0d/%0d want=16/2", uop_vl, uop_sew);
        end
    endtask

    task automatic test_shared_funct6;
        send(arith(6'b100101, 1'b1, 5'd2, 5'd1, 3'b010, 5'd3), 32'h0);
        tests++; if (uop_class !== 2'b00 || uop_op !== 5'd7) begin failed++; $display("FAIL mul_vv got=%0d/%0d want=0/7", uop_class, uop_op); end
        send(arith(6'b100101, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0);
        tests++; if (uop_class !== 2'b00 || uop_op !== 5'd11) begin failed++; $display("FAIL sll_vv got=%0d/%0d want=0/11", uop_class, uop_op); end
        send(arith(6'b100101, 1'b1, 5'd2, 5'd31, 3'b011, 5'd3), 32'h0);
        tests++; if (uop_op !== 5'd11 || uop_src !== 2'b10 || uop_scalar !== 32'h0000001F) begin
            failed++; $display("FAIL sll_vi got=%0d/%0d/%0h want=11/2/1f", uop_op, uop_src, uop_scalar);
        end
        send(arith(6'b000000, 1'b1, 5'd2, 5'd31, 3'b011, 5'd3), 32'h0);
        tests++; if (uop_op !== 5'd1 || uop_scalar !== 32'hFFFFFFFF) begin
            failed++; $display("FAIL add_vi got=%0d/%0h want=1/ffffffff", uop_op, uop_scalar);
        end
        send(arith(6'b000000, 1'b0, 5'd7, 5'd9, 3'b100, 5'd5), 32'hDEADBEEF);
        tests++; if (uop_src !== 2'b01 || uop_scalar !== 32'hDEADBEEF || uop_vm !== 1'b0) begin
            failed++; $display("FAIL add_vx got=%0d/%0h/%b want=1/deadbeef/0", uop_src, uop_scalar, uop_vm);
        end
        send(arith(6'b100111, 1'b1, 5'd2, 5'd4, 3'b110, 5'd3), 32'h55);
        tests++; if (uop_op !== 5'd8 || uop_src !== 2'b01) begin failed++; $display("FAIL mulh_vx got=%0d/%0d want=8/1", uop_op, uop_src); end
    endtask

    task automatic test_illegal_combos;
        logic [31:0] words [6];
        words[0] = arith(6'b000010, 1'b1, 5'd2, 5'd1, 3'b011, 5'd3);
        words[1] = arith(6'b011111, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3);
        words[2] = arith(6'b010111, 1'b1, 5'd2, 5'd1, 3'b000, 5'd3);
        words[3] = {25'h0445003, 7'b0000111};
        words[4] = arith(6'b100101, 1'b1, 5'd2, 5'd1, 3'b011, 5'd3) ^ 32'h00004000;
        words[5] = vsetvli(3'b000, 3'b000, 5'd5, 5'd1) | 32'h80000000;
        for (int i = 0; i < 6; i++) begin
            send(words[i], 32'd7);
            tests++; if (uop_class !== 2'b10 || uop_op !== 5'd0) begin
                failed++; $display("FAIL illegal_%0d got=%0d/%0d want=2/0", i, uop_class, uop_op);
            end
        end
        tests++; if (vl !== 10'd16 || vill !== 1'b0) begin failed++; $display("FAIL vsetvl_state vl=%0d vill=%b want 16/0", vl, vill); end
        send(arith(6'b010111, 1'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'h0);
        tests++; if (uop_class !== 2'b00 || uop_op !== 5'd6) begin failed++; $display("FAIL merge_vm0 got=%0d/%0d want=0/6", uop_class, uop_op); end
    endtask

    task automatic test_cfg_boundaries;
        send(vsetivli(3'b000, 3'b000, 5'd5, 5'd2), 32'hFFFFFFFF);
        tests++; if (uop_vl !== 10'd5 || uop_scalar !== 32'd5 || vl !== 10'd5 || uop_sew !== 2'b00) begin
            failed++; $display("FAIL vsetivli got=%0d/%0d/%0d/%0d want=5/5/5/0", uop_vl, uop_scalar, vl, uop_sew);
        end
        send(vsetvli(3'b000, 3'b011, 5'd0, 5'd1), 32'd3);
        tests++; if (vl !== 10'd512 || uop_vl !== 10'd512) begin failed++; $display("FAIL vlmax_e8m8 got=%0d want=512", vl); end
        send(vsetvli(3'b010, 3'b000, 5'd0, 5'd0), 32'd3);
        tests++; if (vl !== 10'd16 || uop_sew !== 2'b10) begin failed++; $display("FAIL keep_vl_clamp got=%0d/%0d want=16/2", vl, uop_sew); end
        send(vsetvli(3'b001, 3'b001, 5'd5, 5'd1), 32'd3);
        tests++; if (vl !== 10'd3) begin failed++; $display("FAIL avl_small got=%0d want=3", vl); end
        send(vsetvli(3'b001, 3'b001, 5'd5, 5'd1), 32'd1000);
        tests++; if (vl !== 10'd64) begin failed++; $display("FAIL avl_big got=%0d want=64", vl); end
        send(vsetvli(3'b011, 3'b000, 5'd5, 5'd1), 32'd100);
        tests++; if (uop_class !== 2'b01 || vill !== 1'b1 || vl !== 10'd0 || uop_vl !== 10'd0) begin
            failed++; $display("FAIL bad_sew got=%0d/%b/%0d/%0d want=1/1/0/0", uop_class, vill, vl, uop_vl);
        end
        send(vsetvli(3'b010, 3'b000, 5'd5, 5'd1), 32'd100);
        tests++; if (vill !== 1'b0 || vl !== 10'd16) begin failed++; $display("FAIL restore got=%b/%0d want=0/16", vill, vl); end
    endtask

    task automatic test_back_to_back;
        send(vsetvli(3'b001, 3'b000, 5'd5, 5'd1), 32'd200);
        tests++; if (uop_vl !== 10'd32) begin failed++; $display("FAIL b2b_cfg got=%0d want=32", uop_vl); end
        send(32'h022081D7, 32'h0);
        tests++; if (uop_class !== 2'b00 || uop_vl !== 10'd32 || uop_sew !== 2'b01) begin
            failed++; $display("FAIL b2b_arith got=%0d/%0d/%0d want=0/32/1", uop_class, uop_vl, uop_sew);
        end
    endtask

    task automatic test_stall;
        @(posedge clk); #1;
        uop_ready = 1'b0;
        send(arith(6'b000000, 1'b1, 5'd6, 5'd9, 3'b100, 5'd4), 32'h1234);
        instr = arith(6'b000000, 1'b1, 5'd7, 5'd2, 3'b000, 5'd8);
        rs1_value = 32'hFFFF;
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (instr_ready !== 1'b0) begin failed++; $display("FAIL stall_ready_%0d got=%b want=0", i, instr_ready); end
            tests++; if ({uop_valid, uop_op, uop_src, uop_vd, uop_vs2, uop_scalar} !== {1'b1, 5'd1, 2'd1, 5'd4, 5'd6, 32'h1234}) begin
                failed++; $display("FAIL stall_hold_%0d got=%0h want=%0h", i,
                    {uop_valid, uop_op, uop_src, uop_vd, uop_vs2, uop_scalar}, {1'b1, 5'd1, 2'd1, 5'd4, 5'd6, 32'h1234});
            end
        end
        uop_ready = 1'b1;
        #1;
        tests++; if (instr_ready !== 1'b1) begin failed++; $display("FAIL stall_release got=%b want=1", instr_ready); end
        @(posedge clk); #1;
        tests++; if (uop_valid !== 1'b1 || uop_vd !== 5'd8 || uop_src !== 2'b00) begin
            failed++; $display("FAIL b2b_0 got=%b/%0d/%0d want=1/8/0", uop_valid, uop_vd, uop_src);
        end
        instr = arith(6'b001011, 1'b1, 5'd1, 5'd2, 3'b000, 5'd10);
        @(posedge clk); #1;
        tests++; if (uop_vd !== 5'd10 || uop_op !== 5'd5) begin failed++; $display("FAIL b2b_1 got=%0d/%0d want=10/5", uop_vd, uop_op); end
        instr = arith(6'b001001, 1'b1, 5'd1, 5'd2, 3'b000, 5'd11);
        @(posedge clk); #1;
        tests++; if (uop_vd !== 5'd11 || uop_op !== 5'd3) begin failed++; $display("FAIL b2b_2 got=%0d/%0d want=11/3", uop_vd, uop_op); end
        instr_valid = 1'b0;
        @(posedge clk); #1;
        tests++; if (uop_valid !== 1'b0) begin failed++; $display("FAIL drain got=%b want=0", uop_valid); end
    endtask

    task automatic test_reset_inflight;
        uop_ready = 1'b0;
        send(32'h022081D7, 32'h0);
        tests++; if (uop_valid !== 1'b1) begin failed++; $display("FAIL inflight_valid got=%b want=1", uop_valid); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++; if (uop_valid !== 1'b0 || vl !== 10'd0 || vill !== 1'b1 || uop_class !== 2'b00 || uop_vd !== 5'd0) begin
            failed++; $display("FAIL inflight_reset got=%b/%0d/%b/%0d/%0d want=0/0/1/0/0", uop_valid, vl, vill, uop_class, uop_vd);
        end
        uop_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        instr = '0;
        rs1_value = '0;
        instr_valid = 1'b0;
        uop_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_illegal_when_vill();
        test_cfg();
        test_arith();
        test_shared_funct6();
        test_illegal_combos();
        test_cfg_boundaries();
        test_back_to_back();
        test_stall();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vector_instr_decoder.md
Name: vector_instr_decoder

Overview:
- Decode/issue stage of the vector core. Accepts raw 32-bit vector instruction words plus the scalar rs1 value from the scalar core.
- Decodes arithmetic (opcode 1010111, funct3 classes OPIVV/OPIVX/OPIVI/OPMVV/OPMVX) and configuration (OPCFG) instructions into micro-ops for the vector lanes.
- Owns the architectural vl/vtype state.
- One registered pipeline stage with valid/ready on both sides.

Parameters:
- VLEN, 512, vector register length in bits.
- VL_W, $clog2(VLEN)+1, width of vl fields.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_i  in  32  instruction word
- rs1_value_i  in  32  scalar rs1 operand, qualified by instr_valid_i
- instr_valid_i  in  1  instruction offered
- instr_ready_o  out  1  instruction accepted when valid&ready
- uop_valid_o  out  1  micro-op valid
- uop_ready_i  in  1  downstream accepts micro-op
- uop_class_o  out  2  00 ARITH, 01 CFG, 10 ILLEGAL
- uop_op_o  out  5  alu_op_t
- uop_src_o  out  2  00 VV, 01 VX, 10 VI
- uop_vd_o, uop_vs1_o, uop_vs2_o  out  5 each  register indices
- uop_vm_o  out  1  mask-disable bit (instr[25])
- uop_scalar_o  out  32  rs1 value (VX), extended imm (VI), or new vl (CFG)
- uop_vl_o  out  VL_W  vl in force for this uop
- uop_sew_o  out  2  00=8, 01=16, 10=32
- vl_o  out  VL_W  current vl
- vill_o  out  1  current vtype illegal flag

Behaviour:
- Fields: funct6=[31:26], vm=[25], vs2=[24:20], vs1/rs1/imm=[19:15], funct3=[14:12], vd=[11:7], opcode=[6:0].
- Reset (synchronous, active-high, wins over everything):
  - uop_valid_o=0, all uop_* outputs=0.
  - vl_o=0, vill_o=1, sew=00.
  - An in-flight uop is discarded.
- Handshake:
  - instr_ready_o = !uop_valid_o || uop_ready_i.
  - On accept, the decoded uop is registered, so uop_valid_o rises the next cycle (latency 1).
  - While uop_valid_o && !uop_ready_i, every uop_* output holds stable.
  - Full throughput of 1/cycle when uop_ready_i=1.
- funct3 disambiguates shared funct6 codes: 100101 is MUL under OPMVV/OPMVX and SLL under OPIVV/OPIVX/OPIVI.
- Legal arithmetic combinations:
  - ADD, AND, OR, XOR, SRL, SRA, SLL, MSEQ, MSNE, MSLEU, MSLE: VV, VX, VI.
  - SUB, MINU, MIN, MSLTU, MSLT: VV, VX only.
  - MSGTU, MSGT: VX, VI only.
  - MERGE: VV, VX, VI, and requires vm=0.
  - MUL, MULH, MULHU, MULHSU: OPMVV/OPMVX only.
  - Any other combination produces class ILLEGAL with op=NOP.
- Immediates:
  - SLL/SRL/SRA take a zero-extended uimm5.
  - All other VI forms take a sign-extended simm5.
- Illegal conditions:
  - Any ARITH instruction accepted while vill=1 becomes class ILLEGAL.
  - Any opcode other than 1010111 becomes class ILLEGAL.
  - ILLEGAL uops still flow through the handshake; downstream raises the trap.
- OPCFG:
  - instr[31]=0 is vsetvli; instr[31:30]=11 is vsetivli (AVL=uimm5 in [19:15]); instr[31:30]=10 (vsetvl) is ILLEGAL and leaves state unchanged.
  - vtype: vsew=[25:23] (within zimm), vlmul=[22:20].
  - Supported: vsew∈{000,001,010}, vlmul∈{000,001,010,011}. Reserved bits [30:26] must be 0.
  - Unsupported encoding: vill=1, vl=0.
  - VLMAX = (VLEN >> (3+vsew)) << vlmul.
  - vsetvli with rs1=x0 and rd≠x0: AVL=VLMAX. With rs1=x0 and rd=x0: vl keeps its old value, clamped to the new VLMAX.
  - Otherwise vl = min(AVL, VLMAX).
  - The state update happens in the accept cycle. The CFG uop carries the new vl in uop_vl_o and uop_scalar_o (the rd writeback value).
  - The next accepted instruction sees the new vl/vtype; no bubble.
- Every ARITH uop snapshots vl/sew at acceptance.

Decomposition:
- vector_decode_pkg holds:
  - funct6/funct3/opcode constants (load opcode 0000111, store 0100111, arith 1010111).
  - alu_op_t enum: NOP, ADD, SUB, AND, OR, XOR, MERGE, MUL, MULH, MULHU, MULHSU, SLL, SRL, SRA, MSEQ, MSNE, MSLTU, MSLT, MSLEU, MSLE, MSGTU, MSGT, MINU, MIN.
  - uop_class_t, src_sel_t, and a uop_t struct.
- One sub-module, vector_vtype_unit, holds vl/vtype registers and computes VLMAX/vl. The combinational funct6/funct3 decode stays in the top.

Test Plan:
- Reset, then vsetvli x1,x5 (rs1_value_i=100, vsew=010, vlmul=000, VLEN=512) -> CFG uop, uop_vl_o=16, uop_scalar_o=16, vill_o=0.
- After reset, 0x022081D7 (vadd.vv v3,v2,v1) -> ILLEGAL (vill=1). After the config above, same word -> ARITH ADD, VV, vd=3, vs2=2, vs1=1, vm=1, vl=16, one cycle after accept.
- funct6=100101: funct3=010 -> MUL; funct3=000 -> SLL; funct3=011 with imm=11111 -> SLL, scalar=0x0000001F; vadd.vi imm=11111 -> scalar=0xFFFFFFFF.
- vsub.vi, vmsgt.vv, vmerge with vm=1, opcode 0000111 -> each ILLEGAL/NOP.
- uop_ready_i held low 5 cycles with instr_valid_i=1 -> instr_ready_o=0, uop outputs stable. Ready raised -> back-to-back uops, one per cycle.
- Assert reset while uop_valid_o=1 -> next cycle uop_valid_o=0, vl_o=0, vill_o=1.
